// File: rtl/hpdcache_pkg.sv
// Shared HPDcache types and constants used by the CMO front-end slice.
package hpdcache_pkg;

   localparam int unsigned HPDCACHE_PA_WIDTH     = 40;
   localparam int unsigned HPDCACHE_OFFSET_WIDTH = 6;
   localparam int unsigned HPDCACHE_NLINE_WIDTH  = HPDCACHE_PA_WIDTH - HPDCACHE_OFFSET_WIDTH;
   localparam int unsigned HPDCACHE_WORD_WIDTH   = 64;
   localparam int unsigned HPDCACHE_REQ_WORDS    = 2;

   // Consecutive memory-side grants tolerated while a core CMO waits.
   localparam int unsigned HPDCACHE_CMO_STARVE_LIMIT_DEFAULT = 3;

   typedef logic [HPDCACHE_PA_WIDTH-1:0]    hpdcache_req_addr_t;
   typedef logic [HPDCACHE_NLINE_WIDTH-1:0] hpdcache_nline_t;
   typedef logic [HPDCACHE_WORD_WIDTH-1:0]  hpdcache_data_word_t;
   typedef hpdcache_data_word_t [HPDCACHE_REQ_WORDS-1:0] hpdcache_req_data_t;

   // One-hot CMO operation seen by the CMO handler.
   typedef struct packed {
      logic is_fence;
      logic is_inval_by_nline;
      logic is_inval_by_set;
      logic is_inval_all;
   } hpdcache_cmoh_op_t;

   // Operation encoding used for every memory-side line invalidation.
   function automatic hpdcache_cmoh_op_t hpdcache_cmo_op_inval_nline();
      hpdcache_cmoh_op_t op;
      op                   = '0;
      op.is_inval_by_nline = 1'b1;
      return op;
   endfunction

endpackage

// File: rtl/hpdcache_cmo_minv_fifo.sv
// Small synchronous FIFO of cache-line numbers for memory-side invalidations.
// A push is accepted while full only when a pop happens in the same cycle.
module hpdcache_cmo_minv_fifo
   import hpdcache_pkg::*;
#(
   parameter int unsigned DEPTH = 4
)(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            push_i,
   input  hpdcache_nline_t data_i,
   output logic            full_o,
   input  logic            pop_i,
   output hpdcache_nline_t data_o,
   output logic            empty_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   hpdcache_nline_t  mem_r [DEPTH];
   logic [AW-1:0]    wptr_r;
   logic [AW-1:0]    rptr_r;
   logic [AW:0]      cnt_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign empty_o   = (cnt_r == {(AW+1){1'b0}});
   assign full_o    = (cnt_r == (AW+1)'(DEPTH));
   assign do_pop_s  = pop_i & ~empty_o;
   assign do_push_s = push_i & (~full_o | do_pop_s);
   assign data_o    = mem_r[rptr_r];

   // Payload storage; contents are only meaningful under the occupancy count.
   always_ff @(posedge clk_i) begin
      if (do_push_s) begin
         mem_r[wptr_r] <= data_i;
      end
   end

   // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_r <= {AW{1'b0}};
         rptr_r <= {AW{1'b0}};
         cnt_r  <= {(AW+1){1'b0}};
      end else begin
         if (do_push_s) begin
            wptr_r <= wptr_r + AW'(1);
         end
         if (do_pop_s) begin
            rptr_r <= rptr_r + AW'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   cnt_r <= cnt_r + (AW+1)'(1);
            2'b01:   cnt_r <= cnt_r - (AW+1)'(1);
            default: cnt_r <= cnt_r;
         endcase
      end
   end

endmodule

// File: rtl/hpdcache_cmo_arb.sv
// Front-end of the CMO handler: holds one core CMO, buffers memory-side
// invalidations, arbitrates with bounded core starvation and returns a
// tagged completion pulse for core requests.
module hpdcache_cmo_arb
   import hpdcache_pkg::*;
#(
   parameter int unsigned MINV_FIFO_DEPTH = 4,
   parameter int unsigned STARVE_LIMIT    = HPDCACHE_CMO_STARVE_LIMIT_DEFAULT,
   parameter int unsigned TID_WIDTH       = 6
)(
   input  logic                 clk_i,
   input  logic                 rst_i,

   input  logic                 core_req_valid_i,
   output logic                 core_req_ready_o,
   input  hpdcache_cmoh_op_t    core_req_op_i,
   input  hpdcache_req_addr_t   core_req_addr_i,
   input  hpdcache_data_word_t  core_req_wdata_i,
   input  logic [TID_WIDTH-1:0] core_req_tid_i,

   output logic                 core_rsp_valid_o,
   output logic [TID_WIDTH-1:0] core_rsp_tid_o,

   input  logic                 minv_valid_i,
   output logic                 minv_ready_o,
   input  hpdcache_nline_t      minv_nline_i,

   output logic                 cmo_req_valid_o,
   input  logic                 cmo_req_ready_i,
   output hpdcache_cmoh_op_t    cmo_req_op_o,
   output hpdcache_req_addr_t   cmo_req_addr_o,
   output hpdcache_req_data_t   cmo_req_wdata_o,
   output logic                 cmo_req_mem_inval_o,
   output logic                 cmo_busy_o
);

   localparam int unsigned STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

   // Core holding register
   logic                 core_valid_r;
   hpdcache_cmoh_op_t    core_op_r;
   hpdcache_req_addr_t   core_addr_r;
   hpdcache_data_word_t  core_wdata_r;
   logic [TID_WIDTH-1:0] core_tid_r;

   // Arbitration and completion tracking
   logic [STARVE_W-1:0]  starve_cnt_r;
   logic                 busy_r;
   logic                 rsp_pending_r;
   logic [TID_WIDTH-1:0] rsp_tid_r;

   // Memory-invalidation FIFO interface
   logic                 fifo_push_s;
   logic                 fifo_pop_s;
   logic                 fifo_full_s;
   logic                 fifo_empty_s;
   hpdcache_nline_t      fifo_nline_s;

   logic                 core_accept_s;
   logic                 sel_mem_s;
   logic                 grant_s;
   logic                 grant_mem_s;
   logic                 grant_core_s;
   logic                 done_s;

   hpdcache_cmo_minv_fifo #(
      .DEPTH (MINV_FIFO_DEPTH)
   ) i_minv_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (fifo_push_s),
      .data_i  (minv_nline_i),
      .full_o  (fifo_full_s),
      .pop_i   (fifo_pop_s),
      .data_o  (fifo_nline_s),
      .empty_o (fifo_empty_s)
   );

   assign core_req_ready_o = ~core_valid_r;
   assign core_accept_s    = core_req_valid_i & ~core_valid_r;
   assign minv_ready_o     = ~fifo_full_s;
   assign fifo_push_s      = minv_valid_i & ~fifo_full_s;

   // The memory side wins unless the waiting core request has hit the starvation cap.
   assign sel_mem_s       = ~fifo_empty_s & (~core_valid_r | (starve_cnt_r != STARVE_MAX));
   assign cmo_req_valid_o = ~busy_r & (core_valid_r | ~fifo_empty_s);
   assign grant_s         = cmo_req_valid_o & cmo_req_ready_i;
   assign grant_mem_s     = grant_s & sel_mem_s;
   assign grant_core_s    = grant_s & ~sel_mem_s;
   assign fifo_pop_s      = grant_mem_s;

   // Handler is back in idle on the first ready cycle after a grant.
   assign done_s           = busy_r & cmo_req_ready_i;
   assign cmo_busy_o       = busy_r;
   assign core_rsp_valid_o = done_s & rsp_pending_r & ~rst_i;
   assign core_rsp_tid_o   = rsp_tid_r;

   // Request payload steering for the currently selected source.
   always_comb begin
      cmo_req_op_o        = core_op_r;
      cmo_req_addr_o      = core_addr_r;
      cmo_req_wdata_o     = '0;
      cmo_req_mem_inval_o = 1'b0;
      if (sel_mem_s) begin
         cmo_req_op_o        = hpdcache_cmo_op_inval_nline();
         cmo_req_addr_o      = {fifo_nline_s, {HPDCACHE_OFFSET_WIDTH{1'b0}}};
         cmo_req_mem_inval_o = 1'b1;
      end else begin
         cmo_req_wdata_o[0]  = core_wdata_r;
      end
   end

   // Core holding register: capture when empty, release on a core grant.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         core_valid_r <= 1'b0;
         core_op_r    <= '0;
         core_addr_r  <= {HPDCACHE_PA_WIDTH{1'b0}};
         core_wdata_r <= {HPDCACHE_WORD_WIDTH{1'b0}};
         core_tid_r   <= {TID_WIDTH{1'b0}};
      end else if (core_accept_s) begin
         core_valid_r <= 1'b1;
         core_op_r    <= core_req_op_i;
         core_addr_r  <= core_req_addr_i;
         core_wdata_r <= core_req_wdata_i;
         core_tid_r   <= core_req_tid_i;
      end else if (grant_core_s) begin
         core_valid_r <= 1'b0;
      end
   end

   // Starvation counter: memory grants taken while a core request is waiting.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         starve_cnt_r <= {STARVE_W{1'b0}};
      end else if (~core_valid_r | grant_core_s) begin
         starve_cnt_r <= {STARVE_W{1'b0}};
      end else if (grant_mem_s) begin
         starve_cnt_r <= starve_cnt_r + STARVE_W'(1);
      end
   end

   // Busy tracking and the pending core response tag.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         busy_r        <= 1'b0;
         rsp_pending_r <= 1'b0;
         rsp_tid_r     <= {TID_WIDTH{1'b0}};
      end else if (grant_s) begin
         busy_r        <= 1'b1;
         rsp_pending_r <= grant_core_s;
         rsp_tid_r     <= core_tid_r;
      end else if (done_s) begin
         busy_r        <= 1'b0;
         rsp_pending_r <= 1'b0;
      end
   end

endmodule
